// File: rtl/fetch_responder.sv
// Instruction-memory responder: in-order fetch responses after a fixed latency, flushable.
// Optional FETCH_STALL_EN adds LFSR-driven pseudo-random backpressure on reqReady.
module fetch_responder #(
  parameter int WIDTH     = 31,
  parameter int DEPTH_LOG = 7,
  parameter int LATENCY   = 2,
  parameter int Q_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 globalReset,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [WIDTH:0]       reqPC,
  input  logic                 flush,
  output logic                 respValid,
  input  logic                 respReady,
  output logic [WIDTH:0]       respInstr,
  output logic [WIDTH:0]       respPC,
  output logic                 respFault,
  input  logic                 loadEn,
  input  logic [DEPTH_LOG-1:0] loadAddr,
  input  logic [WIDTH:0]       loadData
);
  localparam int PW = $clog2(Q_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]  Q_FULL = CW'(Q_DEPTH);
  localparam logic [WIDTH:0] NOP    = (WIDTH+1)'(32'h0000_0013);

  logic [WIDTH:0] mem [2**DEPTH_LOG];

  always_ff @(posedge clk)
    if (loadEn) mem[loadAddr] <= loadData;

  // Combinational read in the accept cycle; the NBA write above makes a same-edge load read-before-write.
  logic [DEPTH_LOG-1:0] word_idx;
  logic                 req_fault;
  logic [WIDTH:0]       req_instr;
  assign word_idx  = reqPC[DEPTH_LOG+1:2];
  assign req_fault = (|reqPC[1:0]) | (|reqPC[WIDTH:DEPTH_LOG+2]);
  assign req_instr = req_fault ? NOP : mem[word_idx];

  logic stall;
`ifdef FETCH_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  always_ff @(posedge clk)
    if (globalReset) lfsr_q <= 8'hA5;
    else             lfsr_q <= lfsr_d;
  assign stall = &lfsr_q[1:0];
`else
  assign stall = 1'b0;
`endif

  logic [LATENCY-1:0]            vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0]            flt_pipe_q, flt_pipe_d;
  logic [LATENCY-1:0][WIDTH:0]   pc_pipe_q, pc_pipe_d;
  logic [LATENCY-1:0][WIDTH:0]   instr_pipe_q, instr_pipe_d;
  logic [PW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                 cnt_q, cnt_d, occ_q, occ_d;

  logic [WIDTH:0] fifo_pc    [Q_DEPTH];
  logic [WIDTH:0] fifo_instr [Q_DEPTH];
  logic           fifo_fault [Q_DEPTH];

  logic accept, push, pop, resp_valid;

  // Occupancy counts in-flight plus queued entries, so the FIFO can never overflow.
  assign reqReady   = !globalReset && (occ_q < Q_FULL) && !stall;
  assign accept     = reqValid & reqReady & !flush;
  assign resp_valid = !globalReset && (cnt_q != '0);
  assign respValid  = resp_valid;
  assign respPC     = resp_valid ? fifo_pc[rd_ptr_q]    : '0;
  assign respInstr  = resp_valid ? fifo_instr[rd_ptr_q] : '0;
  assign respFault  = resp_valid & fifo_fault[rd_ptr_q];

  always_comb begin
    vld_pipe_d   = '0;
    flt_pipe_d   = '0;
    pc_pipe_d    = '0;
    instr_pipe_d = '0;
    vld_pipe_d[0]   = accept;
    flt_pipe_d[0]   = req_fault;
    pc_pipe_d[0]    = reqPC;
    instr_pipe_d[0] = req_instr;
    for (int i = 1; i < LATENCY; i++) begin
      vld_pipe_d[i]   = vld_pipe_q[i-1];
      flt_pipe_d[i]   = flt_pipe_q[i-1];
      pc_pipe_d[i]    = pc_pipe_q[i-1];
      instr_pipe_d[i] = instr_pipe_q[i-1];
    end
    push     = vld_pipe_q[LATENCY-1] & !flush;
    pop      = resp_valid & respReady & !flush;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    occ_d    = occ_q + CW'(accept) - CW'(pop);
    if (flush) begin
      vld_pipe_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      occ_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (globalReset) begin
      vld_pipe_q   <= '0;
      flt_pipe_q   <= '0;
      pc_pipe_q    <= '0;
      instr_pipe_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      occ_q        <= '0;
    end else begin
      vld_pipe_q   <= vld_pipe_d;
      flt_pipe_q   <= flt_pipe_d;
      pc_pipe_q    <= pc_pipe_d;
      instr_pipe_q <= instr_pipe_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      occ_q        <= occ_d;
    end
  end

  always_ff @(posedge clk)
    if (push && !globalReset) begin
      fifo_pc[wr_ptr_q]    <= pc_pipe_q[LATENCY-1];
      fifo_instr[wr_ptr_q] <= instr_pipe_q[LATENCY-1];
      fifo_fault[wr_ptr_q] <= flt_pipe_q[LATENCY-1];
    end
endmodule

// File: tb/tb_fetch_responder.sv
// Directed bench for fetch_responder (default build, LATENCY=2, Q_DEPTH=4).
module tb_fetch_responder;
  logic        clk = 1'b0;
  logic        globalReset, reqValid, reqReady, flush, respValid, respReady, respFault, loadEn;
  logic [31:0] reqPC, respInstr, respPC, loadData;
  logic [6:0]  loadAddr;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_responder dut (
    .clk(clk), .globalReset(globalReset), .reqValid(reqValid), .reqReady(reqReady),
    .reqPC(reqPC), .flush(flush), .respValid(respValid), .respReady(respReady),
    .respInstr(respInstr), .respPC(respPC), .respFault(respFault),
    .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData)
  );

  task automatic load(input logic [6:0] a, input logic [31:0] d);
    loadEn = 1'b1; loadAddr = a; loadData = d;
    @(negedge clk);
    loadEn = 1'b0;
  endtask

  task automatic test_reset();
    globalReset = 1'b1;
    loadEn = 1'b1; loadAddr = 7'd0; loadData = 32'h0050_0093;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL rst_reqReady: got %b exp 0", reqReady); end
      checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL rst_respValid: got %b exp 0", respValid); end
      checks++; if (respPC !== 32'h0 || respInstr !== 32'h0 || respFault !== 1'b0) begin
        errors++; $display("FAIL rst_resp_data: pc %h instr %h flt %b exp zeros", respPC, respInstr, respFault); end
    end
    loadEn = 1'b0;
    globalReset = 1'b0;
    @(negedge clk);
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL rel_reqReady: got %b exp 1", reqReady); end
    checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL rel_respValid: got %b exp 0", respValid); end
  endtask

  task automatic test_back_to_back();
    respReady = 1'b1; reqValid = 1'b1; reqPC = 32'h0;
    @(negedge clk);
    checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL b2b_lat1: got %b exp 0", respValid); end
    reqPC = 32'h4;
    @(negedge clk);
    checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL b2b_lat2: got %b exp 0", respValid); end
    reqValid = 1'b0;
    @(negedge clk);
    checks++; if (respValid !== 1'b1 || respPC !== 32'h0 || respInstr !== 32'h0050_0093 || respFault !== 1'b0) begin
      errors++; $display("FAIL b2b_resp0: v %b pc %h instr %h flt %b exp 1 0 00500093 0", respValid, respPC, respInstr, respFault); end
    @(negedge clk);
    checks++; if (respValid !== 1'b1 || respPC !== 32'h4 || respInstr !== 32'h0010_8113 || respFault !== 1'b0) begin
      errors++; $display("FAIL b2b_resp1: v %b pc %h instr %h flt %b exp 1 4 00108113 0", respValid, respPC, respInstr, respFault); end
    @(negedge clk);
    checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b exp 0", respValid); end
  endtask

  task automatic test_fault();
    respReady = 1'b1; reqValid = 1'b1; reqPC = 32'h2;
    @(negedge clk);
    reqPC = 32'h200;
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    checks++; if (respValid !== 1'b1 || respPC !== 32'h2 || respInstr !== 32'h13 || respFault !== 1'b1) begin
      errors++; $display("FAIL fault_misalign: v %b pc %h instr %h flt %b exp 1 2 13 1", respValid, respPC, respInstr, respFault); end
    @(negedge clk);
    checks++; if (respValid !== 1'b1 || respPC !== 32'h200 || respInstr !== 32'h13 || respFault !== 1'b1) begin
      errors++; $display("FAIL fault_range: v %b pc %h instr %h flt %b exp 1 200 13 1", respValid, respPC, respInstr, respFault); end
    @(negedge clk);
    checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL fault_drain: got %b exp 0", respValid); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    respReady = 1'b0; reqValid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      reqPC = 32'h10 + 32'(4 * acc);
      if (reqReady === 1'b1) acc++;
      @(negedge clk);
    end
    reqValid = 1'b0;
    checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted: got %0d exp 4", acc); end
    checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b exp 0", reqReady); end
    repeat (2) @(negedge clk);
    checks++; if (respValid !== 1'b1 || respPC !== 32'h10) begin
      errors++; $display("FAIL bp_head: v %b pc %h exp 1 10", respValid, respPC); end
    @(negedge clk);
    checks++; if (respPC !== 32'h10 || respInstr !== 32'hC0DE_0004) begin
      errors++; $display("FAIL bp_head_stable: pc %h instr %h exp 10 c0de0004", respPC, respInstr); end
    respReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (respValid !== 1'b1 || respPC !== 32'h10 + 32'(4 * k) || respInstr !== 32'hC0DE_0004 + 32'(k)) begin
        errors++; $display("FAIL bp_order%0d: v %b pc %h instr %h exp 1 %h %h", k, respValid, respPC, respInstr,
                           32'h10 + 32'(4 * k), 32'hC0DE_0004 + 32'(k)); end
      @(negedge clk);
      if (k == 0) begin
        checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b exp 1", reqReady); end
      end
    end
    checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b exp 0", respValid); end
  endtask

  task automatic test_flush();
    respReady = 1'b0; reqValid = 1'b1; reqPC = 32'h10;
    @(negedge clk);
    reqPC = 32'h14;
    @(negedge clk);
    reqPC = 32'h18;
    @(negedge clk);
    reqPC = 32'h1C; flush = 1'b1; respReady = 1'b1;
    @(negedge clk);
    flush = 1'b0; reqValid = 1'b0;
    checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL flush_resp: got %b exp 0", respValid); end
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", reqReady); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL flush_stale%0d: pc %h exp no response", i, respPC); end
    end
    reqValid = 1'b1; reqPC = 32'h8;
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL flush_new_early: got %b exp 0", respValid); end
    @(negedge clk);
    checks++; if (respValid !== 1'b1 || respPC !== 32'h8 || respInstr !== 32'hAAAA_0000) begin
      errors++; $display("FAIL flush_new_resp: v %b pc %h instr %h exp 1 8 aaaa0000", respValid, respPC, respInstr); end
    @(negedge clk);
    checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL flush_alone: got %b exp 0", respValid); end
  endtask

  task automatic test_read_before_write();
    respReady = 1'b1;
    loadEn = 1'b1; loadAddr = 7'd2; loadData = 32'hBBBB_0000;
    reqValid = 1'b1; reqPC = 32'h8;
    @(negedge clk);
    loadEn = 1'b0;
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    checks++; if (respValid !== 1'b1 || respInstr !== 32'hAAAA_0000) begin
      errors++; $display("FAIL rbw_old: v %b instr %h exp 1 aaaa0000", respValid, respInstr); end
    @(negedge clk);
    checks++; if (respValid !== 1'b1 || respInstr !== 32'hBBBB_0000) begin
      errors++; $display("FAIL rbw_new: v %b instr %h exp 1 bbbb0000", respValid, respInstr); end
    @(negedge clk);
    checks++; if (respValid !== 1'b0) begin errors++; $display("FAIL rbw_drain: got %b exp 0", respValid); end
  endtask

  initial begin
    globalReset = 1'b1; reqValid = 1'b0; reqPC = '0; flush = 1'b0; respReady = 1'b0;
    loadEn = 1'b0; loadAddr = '0; loadData = '0;
    test_reset();
    load(7'd1, 32'h0010_8113);
    load(7'd2, 32'hAAAA_0000);
    for (int i = 4; i < 10; i++) load(7'(i), 32'hC0DE_0000 + 32'(i));
    test_back_to_back();
    test_fault();
    test_backpressure();
    test_flush();
    test_read_before_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_responder.md
Name: fetch_responder

Overview:
Instruction-memory responder on the far end of the core's fetch interface. It accepts fetch requests (PC) from the RISCV core front end and returns instruction words in order after a fixed latency. It buffers up to Q_DEPTH outstanding fetches, supports pipeline flush on redirect, and has a side load port so the simulation bench can preload the program.

Parameters:
WIDTH, 31, MSB index of PC and data buses (buses are [WIDTH:0]).
DEPTH_LOG, 7, log2 of memory size in 32-bit words (128 words).
LATENCY, 2, cycles from request acceptance to response-FIFO entry; legal range 1..4.
Q_DEPTH, 4, maximum outstanding fetches (in flight plus queued); power of two.

Ports:
clk  in  1  system clock, rising edge.
globalReset  in  1  reset; synchronous, active-high.
reqValid  in  1  fetch request valid.
reqReady  out  1  responder can accept a request this cycle.
reqPC  in  WIDTH+1  byte address of the fetch.
flush  in  1  discard all outstanding fetches (branch redirect).
respValid  out  1  response at the head of the response FIFO.
respReady  in  1  core consumes the response.
respInstr  out  WIDTH+1  instruction word.
respPC  out  WIDTH+1  PC the response belongs to.
respFault  out  1  request was misaligned or out of range.
loadEn  in  1  preload write strobe.
loadAddr  in  DEPTH_LOG  preload word index.
loadData  in  WIDTH+1  preload word.

Behaviour:
- Reset: single clock; reset is synchronous and active-high on globalReset. While globalReset is high: reqReady=0, respValid=0, respInstr=0, respPC=0, respFault=0, pipeline and FIFO emptied, occupancy counter=0. The memory array is not cleared. reqReady may go to 1 on the first cycle after reset deasserts.
- Accept: a request is accepted on a rising edge where reqValid&reqReady&!flush.
- reqReady is 1 when (in-flight count + FIFO count) < Q_DEPTH and globalReset=0. It is combinational from registered counts.
- Address decode: word index = reqPC[DEPTH_LOG+1:2].
  - fault = (reqPC[1:0]!=0) | (reqPC[WIDTH:DEPTH_LOG+2]!=0).
  - On fault, instr = 32'h00000013 (NOP) and respFault=1.
- Memory read happens in the accept cycle. If loadEn hits the same word in that cycle, the read returns the old data (read-before-write).
- Latency: the accepted request travels through a LATENCY-stage valid/PC/instr/fault shift pipeline. It is written into the response FIFO at the end of stage LATENCY, so respValid rises exactly LATENCY cycles after acceptance when the FIFO was empty.
- FIFO: Q_DEPTH entries, wrap-around pointers. Pop on respValid&respReady. Push and pop may occur in the same cycle; the count is unchanged. The head stays stable while respValid&!respReady. Overflow cannot occur because of the reqReady occupancy rule.
- Ordering: responses are returned strictly in request order.
- Flush: in the flush cycle, all pipeline stages are invalidated, the FIFO is emptied, and the occupancy counter is set to 0.
  - Any request presented that cycle is dropped.
  - A pop presented that cycle is ignored.
  - respValid=0 on the following cycle; reqReady=1 on the following cycle.
- Load port: a write with loadEn=1 updates memory at the rising edge and is independent of the fetch handshake. Loads are allowed during reset.
- Simultaneous push-into-full plus pop: this is legal and keeps the count at Q_DEPTH.

Optional Feature:
Macro FETCH_STALL_EN.
- Defined: an 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'hA5, steps every cycle when not in reset) gates reqReady low on any cycle where lfsr[1:0]==2'b11. This produces about 25% pseudo-random backpressure for exercising core stall paths. Latency and ordering rules are unchanged.
- Not defined: no LFSR is present, and reqReady depends only on occupancy and reset.

Test Plan:
1. Reset: hold globalReset high for 2 cycles → reqReady=0 and respValid=0 during reset; reqReady=1 in the cycle after release.
2. Preload word 0=32'h00500093 and word 1=32'h00108113, then request PC 0 and PC 4 back-to-back with respReady=1 → respValid on cycles 2 and 3 after the first acceptance, with respPC 0 then 4 and the matching instruction words, and respFault=0.
3. Fault: request PC 0x2 and PC 0x200 → two responses with respFault=1 and respInstr=32'h00000013.
4. Backpressure: respReady=0 while issuing 6 requests → exactly 4 accepted, reqReady=0 afterwards; then release respReady → 4 in-order responses, and reqReady returns to 1 after the first pop.
5. Flush: accept 3 requests, assert flush one cycle after the last → no stale response ever appears; a new request for PC 8 returns alone after LATENCY cycles.
6. Same-cycle load and fetch to word 2 (old 0xAAAA0000, new 0xBBBB0000) → the response carries 0xAAAA0000; a following fetch of word 2 returns 0xBBBB0000.
